egress_arbiter: RTL
===================

Name: egress_arbiter

Overview:
Drains the four output FIFOs (P4..P7) fed by the ingress arbiter and merges them onto a single output stream with valid/ready handshake. Non-empty FIFOs are served round-robin. The FIFOs have a 1-cycle registered read latency, so the block holds a 2-entry output buffer to sustain one beat per cycle under backpressure. It sits at the egress end of the switch, opposite the ingress arbiter's pop/select/push control.

Parameters:
DATA_W, 8, width of FIFO data words and data_out
NUM_PORTS, 4, number of drained FIFOs (fixed at 4; src tag is 2 bits)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
empty_P4..empty_P7  in  1 each  FIFO empty flags, current cycle
data_P4..data_P7  in  DATA_W each  FIFO read data, valid the cycle after the matching pop
pop_F4..pop_F7  out  1 each  combinational pop strobes, at most one high per cycle
data_out  out  DATA_W  head-of-buffer data
src_out  out  2  source FIFO of head beat (0=P4 .. 3=P7)
valid_out  out  1  head beat valid
ready_in  in  1  downstream accepts head when valid_out & ready_in
idle  out  1  occ==0, no pop pending, all four empty flags high

Behaviour:
- Reset (reset=1 at clk edge): rr_ptr=0, occ=0, pend=0, buffer cleared. valid_out=0, data_out=0, src_out=0. Pops are 0 while reset=1. A beat popped the cycle before reset is discarded.
- deq = valid_out & ready_in. Head leaves the buffer on deq.
- Issue condition: pop allowed this cycle iff any empty_Px==0 and (occ + pend - deq) <= 1. This guarantees a slot for the in-flight beat even if ready_in drops.
- Grant: the first non-empty port searching from rr_ptr upward, mod 4. Assert that port's pop_F for exactly this cycle.
- On grant: rr_ptr <= grant+1 mod 4; pend <= 1; pend_src <= grant. With no grant, pend <= 0 and rr_ptr is unchanged.
- Capture: when pend==1, data_P[pend_src] is written at the buffer tail with tag pend_src.
- Occupancy update: occ <= occ + pend - deq.
- Simultaneous capture and deq: both happen in the same cycle.
- Empty buffer with pend: the beat appears on data_out the cycle after capture. Pop-to-valid_out latency is 2 cycles.
- Never pop a FIFO whose empty flag is 1.
- Never overflow: occ never exceeds 2. Dropping a beat is a bug.
- Throughput: with ready_in=1 and data available, one beat per cycle sustained.
- Ordering: beats leave in pop order. Within one source, FIFO order is preserved.
- Stall: with ready_in held 0, data_out/src_out stay stable while valid_out=1.
- The empty flag changing in the same cycle as a pop is the FIFO's concern. The arbiter uses the current-cycle value only.

Decomposition:
- Shared package: NUM_PORTS=4, port index typedef (2 bits), DATA_W default, RR next-pointer function.
- Sub-module egress_skid_buffer: 2-entry FIFO of {src, data} with occ output, push/pop, registered head. The top-level holds the arbitration, rr_ptr, pend and pend_src.

Test Plan:
- Single beat: only P5 holds 0x3C, ready_in=1 -> pop_F5 high for 1 cycle; valid_out=1 with data_out=0x3C, src_out=1 two cycles after the pop; idle=1 afterwards.
- Round-robin: all four FIFOs hold 2 beats each, ready_in=1 -> src_out sequence 0,1,2,3,0,1,2,3, one beat per cycle, 8 consecutive valid cycles.
- Backpressure: ready_in=0 with all FIFOs non-empty -> exactly 2 pops total, then none; occ=2, head held stable. Release ready_in -> remaining beats drain in RR order with no loss or duplication.
- Empty skip: P4 and P6 empty, P5 and P7 with 3 beats each -> pops alternate F5/F7; pop_F4 and pop_F6 never asserted.
- Reset mid-operation: assert reset one cycle after a pop with occ=1 -> next cycle valid_out=0, all pops 0, rr_ptr=0. After release, the first grant goes to the lowest non-empty port; the pre-reset beats never appear.
- Toggling ready_in (1,0,1,0...) with continuous data -> each data_out value is held until accepted, order is preserved, occ never exceeds 2.

Source files
------------

// File: rtl/egress_arbiter_pkg.sv
// Shared definitions for the egress arbiter: port count, port index type,
// default data width and the round-robin pointer advance.
package egress_arbiter_pkg;

    localparam int NUM_PORTS  = 4;
    localparam int DATA_W_DEF = 8;

    typedef logic [1:0] port_idx_t;

    // Next round-robin start position: the port after the one just granted.
    function automatic port_idx_t rr_next(input port_idx_t p);
        return port_idx_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/egress_skid_buffer.sv
// Two-entry buffer of {src, data} beats with a registered head. Absorbs the
// beat already in flight from a FIFO read when the downstream stalls.
module egress_skid_buffer
    import egress_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  port_idx_t         push_src,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output port_idx_t         head_src,
    output logic              head_valid,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] head_data_reg, head_data_next;
    logic [DATA_W-1:0] tail_data_reg, tail_data_next;
    port_idx_t         head_src_reg, head_src_next;
    port_idx_t         tail_src_reg, tail_src_next;
    logic [1:0]        occ_reg, occ_next;
    logic              pop_eff;

    // A pop on an empty buffer is meaningless; ignore it.
    assign pop_eff = pop && (occ_reg != 2'd0);

    // Next-state: shift the tail forward on pop, write the new beat into the
    // first free slot (the head when the buffer is or becomes empty).
    always_comb begin
        head_data_next = head_data_reg;
        head_src_next  = head_src_reg;
        tail_data_next = tail_data_reg;
        tail_src_next  = tail_src_reg;
        occ_next       = occ_reg;
        case (occ_reg)
            2'd0: begin
                if (push) begin
                    head_data_next = push_data;
                    head_src_next  = push_src;
                    occ_next       = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop_eff) begin
                    head_data_next = push_data;
                    head_src_next  = push_src;
                end else if (push) begin
                    tail_data_next = push_data;
                    tail_src_next  = push_src;
                    occ_next       = 2'd2;
                end else if (pop_eff) begin
                    occ_next       = 2'd0;
                end
            end
            default: begin
                // Full: a push is only legal together with a pop.
                if (pop_eff) begin
                    head_data_next = tail_data_reg;
                    head_src_next  = tail_src_reg;
                    if (push) begin
                        tail_data_next = push_data;
                        tail_src_next  = push_src;
                    end else begin
                        occ_next = 2'd1;
                    end
                end
            end
        endcase
    end

    // Buffer state register; reset clears contents so outputs read zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_data_reg <= '0;
            head_src_reg  <= '0;
            tail_data_reg <= '0;
            tail_src_reg  <= '0;
            occ_reg       <= 2'd0;
        end else begin
            head_data_reg <= head_data_next;
            head_src_reg  <= head_src_next;
            tail_data_reg <= tail_data_next;
            tail_src_reg  <= tail_src_next;
            occ_reg       <= occ_next;
        end
    end

    assign head_data  = head_data_reg;
    assign head_src   = head_src_reg;
    assign head_valid = (occ_reg != 2'd0);
    assign occ        = occ_reg;

endmodule

// File: rtl/egress_arbiter.sv
// Round-robin drain of four registered-read FIFOs onto one valid/ready stream.
// A pop is only issued when the skid buffer is sure to have room for the beat
// that arrives one cycle later, so no beat is ever dropped.
module egress_arbiter
    import egress_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              empty_P4,
    input  logic              empty_P5,
    input  logic              empty_P6,
    input  logic              empty_P7,
    input  logic [DATA_W-1:0] data_P4,
    input  logic [DATA_W-1:0] data_P5,
    input  logic [DATA_W-1:0] data_P6,
    input  logic [DATA_W-1:0] data_P7,
    output logic              pop_F4,
    output logic              pop_F5,
    output logic              pop_F6,
    output logic              pop_F7,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        src_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              idle
);

    logic [NUM_PORTS-1:0] empty_vec;
    logic [NUM_PORTS-1:0] pop_vec;
    logic [DATA_W-1:0]    data_arr [NUM_PORTS];

    port_idx_t  rr_reg;
    logic       pend_reg;
    port_idx_t  pend_src_reg;

    port_idx_t  grant;
    logic       found;
    logic       issue;
    logic       deq;
    logic [1:0] occ;
    logic [2:0] budget;
    port_idx_t  head_src;

    assign empty_vec = {empty_P7, empty_P6, empty_P5, empty_P4};
    assign data_arr[0] = data_P4;
    assign data_arr[1] = data_P5;
    assign data_arr[2] = data_P6;
    assign data_arr[3] = data_P7;

    assign deq = valid_out && ready_in;

    // Slots committed after this cycle: buffered + in flight - leaving now.
    // At most one may be committed before another pop is allowed.
    assign budget = {1'b0, occ} + {2'b0, pend_reg} - {2'b0, deq};

    // Grant search: first non-empty port starting at rr_reg, wrapping mod 4.
    always_comb begin
        grant = rr_reg;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            port_idx_t idx;
            idx = rr_reg + port_idx_t'(k);
            if (!found && !empty_vec[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign issue = found && (budget <= 3'd1) && !reset;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_pop
            assign pop_vec[gi] = issue && (grant == port_idx_t'(gi));
        end
    endgenerate

    assign pop_F4 = pop_vec[0];
    assign pop_F5 = pop_vec[1];
    assign pop_F6 = pop_vec[2];
    assign pop_F7 = pop_vec[3];

    // Arbitration state: advance the pointer past each grant and remember
    // which FIFO's read data lands next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_reg       <= '0;
            pend_reg     <= 1'b0;
            pend_src_reg <= '0;
        end else if (issue) begin
            rr_reg       <= rr_next(grant);
            pend_reg     <= 1'b1;
            pend_src_reg <= grant;
        end else begin
            pend_reg     <= 1'b0;
        end
    end

    egress_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (pend_reg),
        .push_src   (pend_src_reg),
        .push_data  (data_arr[pend_src_reg]),
        .pop        (deq),
        .head_data  (data_out),
        .head_src   (head_src),
        .head_valid (valid_out),
        .occ        (occ)
    );

    assign src_out = head_src;
    assign idle    = (occ == 2'd0) && !pend_reg && (&empty_vec);

endmodule
